// File: rtl/instr_fetch_seq.sv
// Instruction fetch/dispatch sequencer.
// Fetches 16-bit words from a synchronous program ROM and dispatches them on
// fullBitNum. It waits for the executors' done handshake, advances pc, then
// clears the instruction register so every opcode-matching executor drops
// back to idle before the next dispatch.
module instr_fetch_seq #(
  parameter int         PC_W    = 8,
  parameter int         TIMEOUT = 15,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [15:0]     mem_data,
  output logic [15:0]     fullBitNum,
  output logic            instr_valid,
  input  logic            PC_inc,
  input  logic            done,
  output logic [PC_W-1:0] pc,
  output logic            halt,
  output logic            fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_RETIRE = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // Counter wide enough to hold TIMEOUT itself; the fault fires on reaching it.
  localparam int               CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [2:0]       state;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             inc_seen;

  // ROM is addressed straight from pc; only the read strobe is sequenced.
  assign mem_addr = pc;
  assign cnt_nxt  = exec_cnt + 1'b1;

  // Sequencer FSM; every output except mem_addr is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      fullBitNum  <= '0;
      instr_valid <= 1'b0;
      mem_rd      <= 1'b0;
      halt        <= 1'b0;
      fault       <= 1'b0;
      exec_cnt    <= '0;
      inc_seen    <= 1'b0;
    end else begin
      // Read strobe is a single-cycle pulse, raised only on entry to ADDR.
      mem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state  <= S_ADDR;
            mem_rd <= 1'b1;
          end
        end
        S_ADDR: state <= S_LATCH;
        S_LATCH: begin
          fullBitNum <= mem_data;
          if (mem_data[15:12] == HALT_OP) begin
            // HALT word is shown but never marked valid; no executor claims it.
            state <= S_HALT;
            halt  <= 1'b1;
          end else begin
            instr_valid <= 1'b1;
            exec_cnt    <= '0;
            inc_seen    <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          exec_cnt <= cnt_nxt;
          // Only the first PC_inc of an instruction advances pc.
          if (PC_inc && !inc_seen) begin
            pc       <= pc + 1'b1;
            inc_seen <= 1'b1;
          end
          if (done) begin
            state <= S_RETIRE;
          end else if (cnt_nxt == TO_VAL) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fullBitNum  <= '0;
            instr_valid <= 1'b0;
          end
        end
        S_RETIRE: begin
          // Clearing the word forces every executor back to idle; a done
          // still held high here is simply not looked at.
          fullBitNum  <= '0;
          instr_valid <= 1'b0;
          if (!inc_seen) pc <= pc + 1'b1;
          if (run) begin
            state  <= S_ADDR;
            mem_rd <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
